// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge: turns the core's fixed-latency memory port into a req/gnt +
// rvalid bus handshake with up to MAX_OUT outstanding transactions, an
// in-order tag FIFO that routes read data back to the core, and a response
// timeout / stray-response detector that parks the bridge in a sticky ERROR
// state until err_clr.
module mem_bus_bridge #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MAX_OUT = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                core_req,
  output logic                core_ready,
  input  logic                core_we,
  input  logic [ADDR_W-1:0]   core_addr,
  input  logic [DATA_W-1:0]   core_wdata,
  input  logic [DATA_W/8-1:0] core_be,
  output logic                core_rvalid,
  output logic [DATA_W-1:0]   core_rdata,
  output logic                bus_req,
  input  logic                bus_gnt,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic                bus_we,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_be,
  input  logic                bus_rvalid,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                err,
  input  logic                err_clr
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  localparam logic [CNT_W:0]   MAX_EXT  = (CNT_W + 1)'(MAX_OUT);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t              state_reg, state_next;

  logic                issue_valid_reg, issue_valid_next;
  logic                issue_we_reg;
  logic [ADDR_W-1:0]   issue_addr_reg;
  logic [DATA_W-1:0]   issue_wdata_reg;
  logic [BE_W-1:0]     issue_be_reg;

  logic [CNT_W-1:0]    count_reg, count_next;
  logic [TMO_W-1:0]    tmo_reg, tmo_next;
  logic [PTR_W-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [MAX_OUT-1:0]  tag_reg;
  logic [MAX_OUT-1:0]  tag_wr;

  logic                rvalid_reg, rvalid_next;
  logic [DATA_W-1:0]   rdata_reg, rdata_next;

  // Holds core_ready low while reset is asserted and for the first edge after.
  logic                ready_en_reg;

  logic in_err, not_full, grant, resp, proto_err, tmo_hit, enter_err, flush;
  logic accept, tag_head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_err    = (state_reg == ST_ERROR);
  assign bus_req   = issue_valid_reg & ~in_err;
  assign not_full  = (count_reg < MAX_CNT);
  assign grant     = bus_req & bus_gnt & not_full;
  // A response only counts when something is outstanding; ERROR ignores it.
  assign resp      = bus_rvalid & ~in_err & (count_reg != '0);
  assign proto_err = bus_rvalid & ~in_err & (count_reg == '0);
  // Fires on the cycle whose edge would bring the counter to TIMEOUT.
  assign tmo_hit   = ~in_err & (count_reg != '0) & ~bus_rvalid & (tmo_reg == TMO_LAST);
  assign enter_err = proto_err | tmo_hit;
  assign flush     = in_err | enter_err;

  assign core_ready = ready_en_reg & ~in_err & (~issue_valid_reg | grant) &
                      (({1'b0, count_reg} + {{CNT_W{1'b0}}, issue_valid_reg}) < MAX_EXT);
  assign accept     = core_req & core_ready;

  assign tag_head  = tag_reg[rd_ptr_reg];

  // One write strobe per tag slot, selected by the FIFO write pointer.
  generate
    for (genvar gi = 0; gi < MAX_OUT; gi++) begin : g_tag_wr
      assign tag_wr[gi] = grant & (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  assign bus_addr    = issue_addr_reg;
  assign bus_we      = issue_we_reg;
  assign bus_wdata   = issue_wdata_reg;
  assign bus_be      = issue_be_reg;
  assign core_rvalid = rvalid_reg;
  assign core_rdata  = rdata_reg;
  assign err         = in_err;

  // Next values for the issue slot, outstanding count, FIFO pointers, timeout
  // counter and the registered read-data return.
  always_comb begin
    issue_valid_next = issue_valid_reg;
    count_next       = count_reg;
    tmo_next         = tmo_reg;
    wr_ptr_next      = wr_ptr_reg;
    rd_ptr_next      = rd_ptr_reg;
    if (flush) begin
      issue_valid_next = 1'b0;
      count_next       = '0;
      tmo_next         = '0;
      wr_ptr_next      = '0;
      rd_ptr_next      = '0;
    end else begin
      if (accept) begin
        issue_valid_next = 1'b1;
      end else if (grant) begin
        issue_valid_next = 1'b0;
      end
      case ({grant, resp})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
      if (grant) wr_ptr_next = ptr_inc(wr_ptr_reg);
      if (resp)  rd_ptr_next = ptr_inc(rd_ptr_reg);
      if ((count_reg == '0) || bus_rvalid) begin
        tmo_next = '0;
      end else begin
        tmo_next = tmo_reg + TMO_W'(1);
      end
    end
    // Write responses pop their tag but never reach the core.
    rvalid_next = resp & ~tag_head;
    rdata_next  = rvalid_next ? bus_rdata : rdata_reg;
  end

  // State transitions: error detection wins, otherwise track activity.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_BUSY: begin
        if (enter_err) begin
          state_next = ST_ERROR;
        end else if (issue_valid_next || (count_next != '0)) begin
          state_next = ST_BUSY;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_ERROR: begin
        if (err_clr) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Control registers: issue-valid, count, pointers, timeout, response return.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_valid_reg <= 1'b0;
      count_reg       <= '0;
      tmo_reg         <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      rvalid_reg      <= 1'b0;
      rdata_reg       <= '0;
      ready_en_reg    <= 1'b0;
    end else begin
      issue_valid_reg <= issue_valid_next;
      count_reg       <= count_next;
      tmo_reg         <= tmo_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      rvalid_reg      <= rvalid_next;
      rdata_reg       <= rdata_next;
      ready_en_reg    <= 1'b1;
    end
  end

  // Issue register fields load on accept and stay put until the next accept,
  // which keeps the bus fields stable while waiting for a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_we_reg    <= 1'b0;
      issue_addr_reg  <= '0;
      issue_wdata_reg <= '0;
      issue_be_reg    <= '0;
    end else if (accept) begin
      issue_we_reg    <= core_we;
      issue_addr_reg  <= core_addr;
      issue_wdata_reg <= core_wdata;
      issue_be_reg    <= core_be;
    end
  end

  // Tag FIFO storage: each granted transaction records whether it was a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_reg <= '0;
    end else begin
      tag_reg <= (tag_reg & ~tag_wr) | (tag_wr & {MAX_OUT{issue_we_reg}});
    end
  end

endmodule
